// File: rtl/program_loader_if.sv
// -----------------------------------------------------------------------------
// program_loader_if
//   Program word stream between an upstream source and the program loader.
//   Signals:
//     in_valid  source -> loader  program word valid
//     in_data   source -> loader  32-bit program word
//     in_last   source -> loader  marks the final program word
//     in_ready  loader -> source  loader accepts a word this cycle
//   Modports:
//     master  upstream source (drives valid/data/last, observes ready)
//     slave   program loader  (observes valid/data/last, drives ready)
// -----------------------------------------------------------------------------
interface program_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Boot/run sequencer for the 8-bit RISC-V pipeline core. Clears instruction
//   memory, streams a program in over a valid/ready port, holds the core in
//   reset to settle, then releases it for a bounded (run_cycles > 0) or
//   unbounded (run_cycles == 0) run.
//
//   Ports:
//     clock, reset      system clock; asynchronous active-high reset
//     start, abort      begin a load session / return to IDLE (abort wins)
//     run_cycles        run length, latched on start
//     in_if (slave)     program word stream (valid/data/last/ready)
//     core_reset        core reset
//     imem_reset        core reset_IF_memory
//     imem_rw           core rw write strobe, one pulse per written word
//     imem_addr         core PC_write
//     imem_wdata        core instruction_in
//     load_count        words written this session
//     checksum          XOR of written words (zero when feature disabled)
//     busy, done        FSM active / FSM in DONE
//     error             overflow this session, sticky until next start
//
//   Configuration macro: LOADER_CHECKSUM_EN
//     defined     checksum accumulates XOR of every written word
//     undefined   checksum is constant zero, no accumulator
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int PC_SIZE       = 10,
  parameter int ADDR_STEP     = 4,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [15:0]        run_cycles,
  program_loader_if.slave    in_if,
  output logic               core_reset,
  output logic               imem_reset,
  output logic               imem_rw,
  output logic [PC_SIZE-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic [PC_SIZE:0]   load_count,
  output logic [31:0]        checksum,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int                 CAPACITY    = (2 ** PC_SIZE) / ADDR_STEP;
  localparam logic [PC_SIZE:0]   CAP_W       = (PC_SIZE + 1)'(CAPACITY);
  localparam logic [PC_SIZE-1:0] STEP_W      = PC_SIZE'(ADDR_STEP);
  localparam logic [15:0]        CLEAR_LAST  = 16'(CLEAR_CYCLES - 1);
  // SETTLE also covers the write cycle of the last word, so it lasts one
  // cycle longer than the settle time measured after that write.
  localparam logic [15:0]        SETTLE_LAST = 16'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        run_q, run_d;
  logic [PC_SIZE-1:0] next_addr_q, next_addr_d;
  logic [PC_SIZE:0]   load_count_q, load_count_d;
  logic               error_q, error_d;
  logic               core_reset_q, core_reset_d;
  logic               imem_reset_q, imem_reset_d;
  logic               imem_rw_q, imem_rw_d;
  logic [PC_SIZE-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic accept_s;
  logic write_s;
  logic new_session_s;

  // in_ready_q is only ever high while in LOAD, so it qualifies the handshake.
  assign accept_s      = in_ready_q & in_if.in_valid;
  assign write_s       = ~abort & accept_s & (load_count_q != CAP_W);
  assign new_session_s = ~abort & start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // Next-state, session counters and registered-output next values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_d        = run_q;
    next_addr_d  = next_addr_q;
    load_count_d = load_count_q;
    error_d      = error_q;
    imem_rw_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (new_session_s) begin
            state_d      = ST_CLEAR;
            cnt_d        = 16'd0;
            run_d        = run_cycles;
            next_addr_d  = '0;
            load_count_d = '0;
            error_d      = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == CLEAR_LAST) begin
            state_d = ST_LOAD;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_LOAD: begin
          if (write_s) begin
            imem_rw_d    = 1'b1;
            imem_addr_d  = next_addr_q;
            imem_wdata_d = in_if.in_data;
            next_addr_d  = next_addr_q + STEP_W;
            load_count_d = load_count_q + {{PC_SIZE{1'b0}}, 1'b1};
            if (in_if.in_last) begin
              state_d = ST_SETTLE;
              cnt_d   = 16'd0;
            end else begin
              state_d = ST_LOAD;
            end
          end else if (accept_s) begin
            // Memory full: the word is dropped and the core is never released.
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_RUN: begin
          if (run_q == 16'd0) begin
            state_d = ST_RUN;
          end else if (cnt_q == (run_q - 16'd1)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    core_reset_d = (state_d != ST_RUN);
    imem_reset_d = (state_d == ST_CLEAR);
    in_ready_d   = (state_d == ST_LOAD);
    busy_d       = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d       = (state_d == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      run_q        <= 16'd0;
      next_addr_q  <= '0;
      load_count_q <= '0;
      error_q      <= 1'b0;
      core_reset_q <= 1'b1;
      imem_reset_q <= 1'b0;
      imem_rw_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_q        <= run_d;
      next_addr_q  <= next_addr_d;
      load_count_q <= load_count_d;
      error_q      <= error_d;
      core_reset_q <= core_reset_d;
      imem_reset_q <= imem_reset_d;
      imem_rw_q    <= imem_rw_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  function automatic logic [31:0] checksum_fold(input logic [31:0] acc,
                                                input logic [31:0] word);
    return acc ^ word;
  endfunction

  // Accumulator: cleared on a new session, folded on every written word.
  always_comb begin
    checksum_d = checksum_q;
    if (new_session_s) begin
      checksum_d = 32'd0;
    end else if (write_s) begin
      checksum_d = checksum_fold(checksum_q, in_if.in_data);
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      checksum_q <= 32'd0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif

  assign in_if.in_ready = in_ready_q;
  assign core_reset     = core_reset_q;
  assign imem_reset     = imem_reset_q;
  assign imem_rw        = imem_rw_q;
  assign imem_addr      = imem_addr_q;
  assign imem_wdata     = imem_wdata_q;
  assign load_count     = load_count_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Directed session sequence with randomized program words and run lengths.
//   Expected writes, counts, run lengths and checksums come from a simple
//   session model: word i lands at address i*ADDR_STEP until the memory is
//   full, the run lasts run_cycles cycles, the checksum is the XOR of the
//   written words.
// -----------------------------------------------------------------------------
module tb_program_loader;
  localparam int PC_SIZE       = 10;
  localparam int ADDR_STEP     = 4;
  localparam int CLEAR_CYCLES  = 2;
  localparam int SETTLE_CYCLES = 4;
  localparam int CAPACITY      = (1 << PC_SIZE) / ADDR_STEP;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic               abort;
  logic [15:0]        run_cycles;
  logic               core_reset, imem_reset, imem_rw;
  logic [PC_SIZE-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic [PC_SIZE:0]   load_count;
  logic [31:0]        checksum;
  logic               busy, done, error;

  program_loader_if in_if ();

  program_loader #(
    .PC_SIZE(PC_SIZE), .ADDR_STEP(ADDR_STEP),
    .CLEAR_CYCLES(CLEAR_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .run_cycles(run_cycles), .in_if(in_if),
    .core_reset(core_reset), .imem_reset(imem_reset), .imem_rw(imem_rw),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .load_count(load_count),
    .checksum(checksum), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc, low_cnt, clr_cnt, last_wr_cyc, first_low_cyc;
  logic [PC_SIZE-1:0] wr_addr[$];
  logic [31:0]        wr_data[$];
  logic [31:0]        words[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clock);
    cyc++;
    if (imem_rw === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      last_wr_cyc = cyc;
    end
    if (core_reset === 1'b0) begin
      if (low_cnt == 0) first_low_cyc = cyc;
      low_cnt++;
    end
    if (imem_reset === 1'b1) clr_cnt++;
  endtask

  task automatic clear_log();
    cyc = 0; low_cnt = 0; clr_cnt = 0; last_wr_cyc = 0; first_low_cyc = 0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic start_session(input logic [15:0] n);
    clear_log();
    run_cycles = n;
    start = 1'b1;
    step();
    start = 1'b0;
    run_cycles = 16'($urandom);
    check("start_load_count", load_count, 32'd0);
    check("start_error", error, 32'd0);
    check("start_checksum", checksum, 32'd0);
    check("start_busy", busy, 32'd1);
    for (int g = 0; g < 20 && in_if.in_ready !== 1'b1; g++) step();
    check("load_ready", in_if.in_ready, 32'd1);
    check("clear_len", clr_cnt, CLEAR_CYCLES);
  endtask

  task automatic send_words(input int gap, input int upto);
    for (int i = 0; i < upto; i++) begin
      bit acc = 1'b0;
      in_if.in_valid = 1'b1;
      in_if.in_data  = words[i];
      in_if.in_last  = (i == words.size() - 1);
      for (int g = 0; g < 50 && !acc; g++) begin
        acc = (in_if.in_ready === 1'b1);
        step();
      end
      in_if.in_valid = 1'b0;
      in_if.in_last  = 1'b0;
      check("accept", 32'(acc), 32'd1);
      if (i == 0) begin
        for (int g = 0; g < gap; g++) begin
          in_if.in_data = $urandom;
          step();
          check("ready_gap", in_if.in_ready, 32'd1);
        end
      end
    end
  endtask

  task automatic wait_done();
    for (int g = 0; g < 3000 && done !== 1'b1; g++) step();
    check("done", done, 32'd1);
  endtask

  task automatic check_session(input int nw, input logic [15:0] n);
    int exp_n;
    bit ovf;
    logic [31:0] exp_cs;
    ovf   = (nw > CAPACITY);
    exp_n = ovf ? CAPACITY : nw;
    exp_cs = 32'd0;
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < exp_n; i++) exp_cs = exp_cs ^ words[i];
`endif
    check("wr_count", wr_addr.size(), exp_n);
    for (int i = 0; i < exp_n && i < wr_addr.size(); i++) begin
      check("wr_addr", 32'(wr_addr[i]), (i * ADDR_STEP) % (1 << PC_SIZE));
      check("wr_data", wr_data[i], words[i]);
    end
    check("load_count", load_count, exp_n);
    check("error", error, 32'(ovf));
    check("checksum", checksum, exp_cs);
    if (ovf) begin
      check("ovf_core_held", low_cnt, 32'd0);
    end else begin
      check("run_len", low_cnt, n);
      check("settle_len", first_low_cyc - last_wr_cyc - 1, SETTLE_CYCLES);
    end
    check("done_core_reset", core_reset, 32'd1);
    check("done_busy", busy, 32'd0);
  endtask

  initial begin
    logic [15:0] n;
    int nw;
    reset = 1'b1; start = 1'b0; abort = 1'b0; run_cycles = 16'd0;
    in_if.in_valid = 1'b0; in_if.in_data = 32'd0; in_if.in_last = 1'b0;
    clear_log();
    step(); step();
    check("rst_core_reset", core_reset, 32'd1);
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_ready", in_if.in_ready, 32'd0);
    check("rst_rw", imem_rw, 32'd0);
    check("rst_imem_reset", imem_reset, 32'd0);
    check("rst_load_count", load_count, 32'd0);
    reset = 1'b0;
    step();
    check("idle_core_reset", core_reset, 32'd1);
    check("idle_busy", busy, 32'd0);

    // Three words, ten-cycle run.
    fill_random(3);
    start_session(16'd10);
    send_words(0, 3);
    wait_done();
    check_session(3, 16'd10);

    // One word, five idle cycles, last word; start during RUN is ignored.
    fill_random(2);
    n = 16'($urandom_range(3, 20));
    start_session(n);
    send_words(5, 2);
    for (int g = 0; g < 50 && core_reset !== 1'b0; g++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    check_session(2, n);

    // Overflow: one word more than the memory holds.
    fill_random(CAPACITY + 1);
    start_session(16'd5);
    send_words(0, CAPACITY + 1);
    wait_done();
    check_session(CAPACITY + 1, 16'd5);

    // Unbounded run, then abort together with start.
    nw = $urandom_range(1, 4);
    fill_random(nw);
    start_session(16'd0);
    check("error_cleared", error, 32'd0);
    send_words(0, nw);
    for (int g = 0; g < 500 && low_cnt < 100; g++) step();
    check("unbounded_run", low_cnt, 32'd100);
    check("unbounded_core_low", core_reset, 32'd0);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("abort_core_reset", core_reset, 32'd1);
    check("abort_busy", busy, 32'd0);
    check("abort_done", done, 32'd0);
    check("abort_ready", in_if.in_ready, 32'd0);
    check("abort_rw", imem_rw, 32'd0);
    check("abort_imem_reset", imem_reset, 32'd0);
    check("abort_load_count", load_count, nw);
    step();
    check("abort_stays_idle", busy, 32'd0);

    // Abort during LOAD after two words, then a fresh session.
    fill_random(4);
    start_session(16'd7);
    send_words(0, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_load_busy", busy, 32'd0);
    check("abort_load_count", load_count, 32'd2);
    check("abort_load_core", core_reset, 32'd1);
    fill_random(3);
    start_session(16'd6);
    send_words(0, 3);
    wait_done();
    check_session(3, 16'd6);

    // Known checksum pair.
    words.delete();
    words.push_back(32'h0000_0013);
    words.push_back(32'h0010_0093);
    start_session(16'd3);
    send_words(0, 2);
    wait_done();
    check_session(2, 16'd3);
`ifdef LOADER_CHECKSUM_EN
    check("checksum_known", checksum, 32'h0010_0080);
`else
    check("checksum_known", checksum, 32'h0000_0000);
`endif

    // Asynchronous reset in the middle of LOAD.
    fill_random(3);
    start_session(16'd5);
    send_words(0, 1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_core_reset", core_reset, 32'd1);
    check("areset_busy", busy, 32'd0);
    check("areset_ready", in_if.in_ready, 32'd0);
    check("areset_load_count", load_count, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();
    check("areset_idle", busy, 32'd0);

    // Randomized sessions.
    for (int s = 0; s < 4; s++) begin
      nw = $urandom_range(1, 6);
      n  = 16'($urandom_range(1, 15));
      fill_random(nw);
      start_session(n);
      send_words($urandom_range(0, 3), nw);
      wait_done();
      check_session(nw, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
